// File: rtl/caravel_io_pkg.sv
// rtl/caravel_io_pkg.sv - shared state encoding, flash command and default parameters
`timescale 1ns/1ps
package caravel_io_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    CMD      = 3'd1,
    LEN      = 3'd2,
    FETCH    = 3'd3,
    HOLD     = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [7:0]  SPI_READ_CMD        = 8'h03;
  localparam logic [23:0] DEF_FLASH_BASE_ADDR = 24'h000000;
  localparam int          DEF_SCK_HALF        = 2;
  localparam int          DEF_HOLD_CYCLES     = 64;

  // Chip select stays low for the whole continuous read, including HOLD pauses.
  function automatic logic flash_selected(state_t s);
    return (s == CMD) || (s == LEN) || (s == FETCH) || (s == HOLD);
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// rtl/spi_byte_shifter.sv - mode-0 SPI shifter: SCK divider, 8/32-bit MSB-first out, 8-bit in
`timescale 1ns/1ps
module spi_byte_shifter #(
  parameter int SCK_HALF = 2
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        abort,
  input  logic        start,
  input  logic        len32,
  input  logic [31:0] tx_data,
  input  logic        io1,
  output logic        sck,
  output logic        io0,
  output logic [7:0]  rx_byte,
  output logic [7:0]  rx_next,
  output logic        last_sample,
  output logic        done
);

  localparam int DW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

  logic          busy;
  logic [DW-1:0] div;
  logic [5:0]    bit_cnt;
  logic [31:0]   sr;
  logic [7:0]    rx_q;
  logic          tick;

  assign tick        = busy && (div == DW'(SCK_HALF - 1));
  assign last_sample = tick && !sck && (bit_cnt == 6'd1);
  assign done        = tick && sck && (bit_cnt == 6'd1);
  assign rx_next     = {rx_q[6:0], io1};
  assign rx_byte     = rx_q;
  assign io0         = busy & sr[31];

  // Each bit is a low half (io0 settles) followed by a high half; io1 is taken on the rise.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      busy    <= 1'b0;
      sck     <= 1'b0;
      div     <= '0;
      bit_cnt <= '0;
      sr      <= '0;
      rx_q    <= '0;
    end else if (abort) begin
      busy    <= 1'b0;
      sck     <= 1'b0;
      div     <= '0;
      bit_cnt <= '0;
      sr      <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      sck     <= 1'b0;
      div     <= '0;
      bit_cnt <= len32 ? 6'd32 : 6'd8;
      sr      <= len32 ? tx_data : {tx_data[7:0], 24'h000000};
    end else if (busy) begin
      if (tick) begin
        div <= '0;
        if (!sck) begin
          sck  <= 1'b1;
          rx_q <= rx_next;
        end else begin
          sck     <= 1'b0;
          sr      <= {sr[30:0], 1'b0};
          bit_cnt <= bit_cnt - 6'd1;
          if (bit_cnt == 6'd1) busy <= 1'b0;
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/caravel_io_player.sv
// rtl/caravel_io_player.sv - replays a flash-resident byte program onto mprj_io[7:0]
`timescale 1ns/1ps
module caravel_io_player
  import caravel_io_pkg::*;
#(
  parameter logic [23:0] FLASH_BASE_ADDR = DEF_FLASH_BASE_ADDR,
  parameter int          SCK_HALF        = DEF_SCK_HALF,
  parameter int          HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        vccd_pg,
  input  logic        vccd1_pg,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1,
  output logic [37:0] mprj_io,
  output logic        gpio
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  state_t        state, state_next;
  logic          pg_ok;
  logic          csb_q;
  logic          gpio_q;
  logic [7:0]    mprj_q;
  logic [7:0]    remaining;
  logic [HW-1:0] hold_cnt;
  logic          start, len32;
  logic [31:0]   tx_data;
  logic [7:0]    rx_byte, rx_next;
  logic          last_sample, done;

  assign pg_ok = vccd_pg & vccd1_pg;

  spi_byte_shifter #(.SCK_HALF(SCK_HALF)) u_shifter (
    .clock       (clock),
    .resetb      (resetb),
    .abort       (!pg_ok),
    .start       (start),
    .len32       (len32),
    .tx_data     (tx_data),
    .io1         (flash_io1),
    .sck         (flash_clk),
    .io0         (flash_io0),
    .rx_byte     (rx_byte),
    .rx_next     (rx_next),
    .last_sample (last_sample),
    .done        (done)
  );

  // Transfers are chained back-to-back: the next one starts on the done cycle of the last.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    len32      = 1'b0;
    tx_data    = '0;
    if (!pg_ok) begin
      state_next = PWR_WAIT;
    end else begin
      unique case (state)
        PWR_WAIT: begin
          state_next = CMD;
          start      = 1'b1;
          len32      = 1'b1;
          tx_data    = {SPI_READ_CMD, FLASH_BASE_ADDR};
        end
        CMD: begin
          if (done) begin
            state_next = LEN;
            start      = 1'b1;
          end
        end
        LEN: begin
          if (done) begin
            if (rx_byte == 8'd0) begin
              state_next = DONE;
            end else begin
              state_next = FETCH;
              start      = 1'b1;
            end
          end
        end
        FETCH: begin
          if (done) state_next = HOLD;
        end
        HOLD: begin
          if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            if (remaining != 8'd0) begin
              state_next = FETCH;
              start      = 1'b1;
            end else begin
              state_next = DONE;
            end
          end
        end
        DONE:    state_next = DONE;
        default: state_next = PWR_WAIT;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state     <= PWR_WAIT;
      csb_q     <= 1'b1;
      gpio_q    <= 1'b0;
      mprj_q    <= '0;
      remaining <= '0;
      hold_cnt  <= '0;
    end else begin
      state    <= state_next;
      csb_q    <= !flash_selected(state_next);
      gpio_q   <= (state_next == DONE);
      hold_cnt <= ((state == HOLD) && (state_next == HOLD)) ? hold_cnt + 1'b1 : '0;
      if (!pg_ok) begin
        mprj_q    <= '0;
        remaining <= '0;
      end else if ((state == LEN) && done) begin
        remaining <= rx_byte;
      end else if ((state == FETCH) && last_sample) begin
        // Latch on the final sample so the pin moves exactly once per entry.
        mprj_q    <= rx_next;
        remaining <= remaining - 8'd1;
      end
    end
  end

  assign flash_csb = csb_q;
  assign gpio      = gpio_q;
  assign mprj_io   = {30'd0, mprj_q};

endmodule

// File: tb/tb_caravel_io_player.sv
// tb/tb_caravel_io_player.sv - scoreboard bench with SPI flash model for caravel_io_player
`timescale 1ns/1ps
module tb_caravel_io_player;

  localparam int SH        = 2;
  localparam int HC        = 64;
  localparam int ENTRY_CYC = HC + 16 * SH;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic        vccd_pg = 1'b0;
  logic        vccd1_pg = 1'b0;
  logic        flash_csb, flash_clk, flash_io0;
  logic        flash_io1 = 1'b0;
  logic [37:0] mprj_io;
  logic        gpio;

  caravel_io_player #(
    .FLASH_BASE_ADDR (24'h000000),
    .SCK_HALF        (SH),
    .HOLD_CYCLES     (HC)
  ) dut (
    .clock     (clock),
    .resetb    (resetb),
    .vccd_pg   (vccd_pg),
    .vccd1_pg  (vccd1_pg),
    .flash_csb (flash_csb),
    .flash_clk (flash_clk),
    .flash_io0 (flash_io0),
    .flash_io1 (flash_io1),
    .mprj_io   (mprj_io),
    .gpio      (gpio)
  );

  always #12.5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
  endtask

  // SPI flash: 32-bit READ header on rising SCK, then continuous data out on falling SCK.
  logic [7:0]  flash_mem [256];
  int          fl_bits = 0;
  int          fl_obit = 0;
  logic [31:0] fl_sr = '0;
  logic [23:0] fl_addr = '0;
  logic [7:0]  fl_byte;
  int          last_rise = 0;
  bit          cmd_checked = 1'b0;

  always @(posedge flash_clk or negedge flash_clk or posedge flash_csb) begin
    if (flash_csb) begin
      fl_bits   = 0;
      fl_obit   = 0;
      flash_io1 = 1'b0;
    end else if (flash_clk) begin
      if (fl_bits < 32) begin
        if (!cmd_checked && fl_bits == 1) chk("sck_period", 64'(cyc - last_rise), 64'(2 * SH));
        last_rise = cyc;
        fl_sr     = {fl_sr[30:0], flash_io0};
        fl_bits++;
        if (fl_bits == 32) begin
          fl_addr = fl_sr[23:0];
          if (!cmd_checked) begin
            chk("cmd_word", 64'(fl_sr), 64'h03000000);
            cmd_checked = 1'b1;
          end
        end
      end
    end else if (fl_bits == 32) begin
      fl_byte   = flash_mem[fl_addr[7:0]];
      flash_io1 = fl_byte[7 - fl_obit];
      fl_obit++;
      if (fl_obit == 8) begin
        fl_obit = 0;
        fl_addr = fl_addr + 24'd1;
      end
    end
  end

  int csb_rises = 0;
  always @(posedge flash_csb) csb_rises++;

  // Reference: visible pin changes are the entries with consecutive repeats collapsed;
  // each change lands a whole number of entry periods after the previous one.
  typedef struct {
    logic [7:0] val;
    int         gap;
    bit         chk_gap;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] img[$];
  logic [7:0] mon_prev = 8'h00;
  int         last_chg = 0;
  exp_t       mon_e;

  always @(negedge clock) begin
    if (mprj_io[7:0] !== mon_prev) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_change actual=%0h required=no_change at cycle %0d", mprj_io[7:0], cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("entry_value", 64'(mprj_io[7:0]), 64'(mon_e.val));
        chk("upper_io_zero", 64'(mprj_io[37:8]), 64'd0);
        if (mon_e.chk_gap) chk("entry_spacing", 64'(cyc - last_chg), 64'(mon_e.gap));
      end
      last_chg = cyc;
      mon_prev = mprj_io[7:0];
    end
  end

  task automatic load_and_expect(input bit expect_clear);
    exp_t       t;
    logic [7:0] prev;
    int         k;
    bit         first;
    for (int i = 0; i < 256; i++) flash_mem[i] = 8'h00;
    for (int i = 0; i < img.size(); i++) flash_mem[i] = img[i];
    exp_q.delete();
    if (expect_clear) begin
      t.val = 8'h00; t.gap = 0; t.chk_gap = 1'b0;
      exp_q.push_back(t);
    end
    prev  = 8'h00;
    k     = 0;
    first = 1'b1;
    for (int i = 1; i <= int'(img[0]); i++) begin
      k++;
      if (img[i] != prev) begin
        t.val = img[i]; t.gap = k * ENTRY_CYC; t.chk_gap = !first;
        exp_q.push_back(t);
        first = 1'b0;
        k     = 0;
        prev  = img[i];
      end
    end
  endtask

  task automatic begin_restart();
    @(posedge clock); #3;
    load_and_expect(mon_prev != 8'h00);
    resetb = 1'b0;
  endtask

  task automatic end_restart();
    repeat (4) @(posedge clock);
    #3 resetb = 1'b1;
  endtask

  task automatic wait_mprj(input string name, input logic [7:0] v, input int max);
    int n = 0;
    while (mprj_io[7:0] !== v && n < max) begin
      @(posedge clock); #1;
      n++;
    end
    chk(name, 64'(mprj_io[7:0]), 64'(v));
  endtask

  task automatic wait_gpio(input int max);
    int n = 0;
    while (gpio !== 1'b1 && n < max) begin
      @(posedge clock); #1;
      n++;
    end
    chk("gpio_done", 64'(gpio), 64'd1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("done_csb_high", 64'(flash_csb), 64'd1);
    chk("done_sck_low", 64'(flash_clk), 64'd0);
  endtask

  task automatic set_image1();
    img.delete();
    img.push_back(8'h0C);
    for (int i = 1; i <= 10; i++) img.push_back(8'(i));
    img.push_back(8'hFF);
    img.push_back(8'h00);
  endtask

  int csb0;
  int n_ent;
  logic [7:0] rv;

  initial begin
    set_image1();
    load_and_expect(1'b0);

    #800 vccd_pg = 1'b1; vccd1_pg = 1'b1;
    #200;
    chk("rst_csb", 64'(flash_csb), 64'd1);
    chk("rst_sck", 64'(flash_clk), 64'd0);
    chk("rst_io0", 64'(flash_io0), 64'd0);
    chk("rst_mprj", 64'(mprj_io), 64'd0);
    chk("rst_gpio", 64'(gpio), 64'd0);
    #1000 resetb = 1'b1;

    // Full program, first-entry latency and continuous chip select.
    csb0 = csb_rises;
    wait_mprj("first_entry_latency", 8'h01, 1 + 96 * SH + 2);
    wait_gpio(25000);
    chk("csb_low_throughout", 64'(csb_rises - csb0), 64'd1);
    chk("last_entry_kept", 64'(mprj_io[7:0]), 64'h00);

    // Empty program.
    img.delete();
    img.push_back(8'h00);
    begin_restart();
    end_restart();
    csb0 = csb_rises;
    wait_gpio(2000);
    chk("empty_mprj", 64'(mprj_io), 64'd0);
    chk("empty_csb_once", 64'(csb_rises - csb0), 64'd1);

    // Reset pulse during entry 5.
    set_image1();
    begin_restart();
    end_restart();
    wait_mprj("reach_entry5", 8'h05, 25000);
    repeat (10) @(posedge clock);
    begin_restart();
    #1;
    chk("abort_rst_mprj", 64'(mprj_io), 64'd0);
    chk("abort_rst_csb", 64'(flash_csb), 64'd1);
    chk("abort_rst_gpio", 64'(gpio), 64'd0);
    chk("abort_rst_sck", 64'(flash_clk), 64'd0);
    end_restart();
    wait_mprj("restart_first", 8'h01, 1 + 96 * SH + 2);
    wait_gpio(25000);

    // User power-good drop while holding entry 3.
    begin_restart();
    end_restart();
    wait_mprj("reach_entry3", 8'h03, 25000);
    repeat (20) @(posedge clock);
    #3;
    load_and_expect(mon_prev != 8'h00);
    vccd1_pg = 1'b0;
    @(posedge clock); #1;
    chk("pgdrop_mprj", 64'(mprj_io), 64'd0);
    chk("pgdrop_csb", 64'(flash_csb), 64'd1);
    chk("pgdrop_gpio", 64'(gpio), 64'd0);
    repeat (10) @(posedge clock);
    #1 chk("pgwait_csb", 64'(flash_csb), 64'd1);
    #2 vccd1_pg = 1'b1;
    wait_gpio(25000);

    // Random programs with frequent repeated entries.
    for (int r = 0; r < 3; r++) begin
      n_ent = $urandom_range(1, 12);
      img.delete();
      img.push_back(8'(n_ent));
      rv = 8'h00;
      for (int i = 0; i < n_ent; i++) begin
        if ($urandom_range(0, 2) != 0) rv = 8'($urandom_range(0, 255));
        img.push_back(rv);
      end
      begin_restart();
      end_restart();
      wait_gpio(25000);
      chk("rand_last_entry", 64'(mprj_io[7:0]), 64'(img[n_ent]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
